// File: rtl/expr_pkg.sv
// Shared constants for the expression string generator and its recognizer.
package expr_pkg;

  // Operator codes carried on the ops bus
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // ASCII characters produced on out_char
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_NINE  = 8'h39;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_STAR  = 8'h2A;
  localparam logic [7:0] ASC_SLASH = 8'h2F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit range test shared with the recognizer side
  function automatic logic is_ascii_digit(input logic [7:0] c);
    return (c >= ASC_ZERO) && (c <= ASC_NINE);
  endfunction

endpackage

// File: rtl/expr_char_enc.sv
// Maps {is_op, value} to an ASCII character: BCD digit or operator symbol.
module expr_char_enc
  import expr_pkg::*;
(
  input  logic       is_op_i,
  input  logic [3:0] val_i,
  output logic [7:0] char_o
);

  // Digit path adds the ASCII '0' offset; operator path is a 4-entry table
  always_comb begin
    char_o = ASC_ZERO + {4'b0000, val_i};
    if (is_op_i) begin
      case (val_i[1:0])
        OP_ADD:  char_o = ASC_PLUS;
        OP_SUB:  char_o = ASC_MINUS;
        OP_MUL:  char_o = ASC_STAR;
        default: char_o = ASC_SLASH;
      endcase
    end
  end

endmodule

// File: rtl/expr_string_gen.sv
// Serializes a packed arithmetic expression as ASCII bytes over a
// valid/ready handshake: digit, op, digit, ..., digit.
module expr_string_gen
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 4,
  parameter int CNT_W     = 3
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       start,
  input  logic [CNT_W-1:0]           nterms,
  input  logic [4*MAX_TERMS-1:0]     digits,
  input  logic [2*(MAX_TERMS-1)-1:0] ops,
  input  logic                       out_ready,
  output logic [7:0]                 out_char,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int DIG_W  = 4 * MAX_TERMS;
  localparam int OPS_W  = 2 * (MAX_TERMS - 1);
  localparam int HALF_W = CNT_W - 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic [OPS_W-1:0]   ops_q, ops_d;
  logic [CNT_W-1:0]   nterms_q, nterms_d;
  logic [7:0]         out_char_q, out_char_d;
  logic               err_q, err_d;

  // Start validation: count in range and every used digit is BCD
  logic [MAX_TERMS-1:0] term_bad;
  logic                 start_ok;

  for (genvar gi = 0; gi < MAX_TERMS; gi++) begin : g_check
    assign term_bad[gi] = (CNT_W'(gi) < nterms) && (digits[4*gi +: 4] > 4'd9);
  end

  assign start_ok = (nterms != '0) && (nterms <= CNT_W'(MAX_TERMS)) && ~|term_bad;

  // Source of the next character: the live buses when launching from IDLE,
  // otherwise the latched operands at the following index.
  logic               from_inputs;
  logic [CNT_W-1:0]   enc_idx;
  logic [DIG_W-1:0]   src_digits;
  logic [OPS_W-1:0]   src_ops;
  logic [3:0]         dig_arr [MAX_TERMS];
  logic [1:0]         op_arr  [MAX_TERMS];
  logic [HALF_W-1:0]  enc_half;
  logic               enc_is_op;
  logic [3:0]         enc_val;
  logic [7:0]         enc_char;

  // Select operand source and index of the character to load next
  always_comb begin
    from_inputs = (state_q == IDLE);
    enc_idx     = from_inputs ? '0 : idx_q + CNT_W'(1);
    src_digits  = from_inputs ? digits : digits_q;
    src_ops     = from_inputs ? ops : ops_q;
  end

  for (genvar gi = 0; gi < MAX_TERMS; gi++) begin : g_unpack
    assign dig_arr[gi] = src_digits[4*gi +: 4];
    if (gi < MAX_TERMS - 1) begin : g_op
      assign op_arr[gi] = src_ops[2*gi +: 2];
    end else begin : g_pad
      assign op_arr[gi] = 2'b00;
    end
  end

  assign enc_half  = enc_idx[CNT_W-1:1];
  assign enc_is_op = enc_idx[0];
  assign enc_val   = enc_is_op ? {2'b00, op_arr[enc_half]} : dig_arr[enc_half];

  expr_char_enc u_enc (
    .is_op_i (enc_is_op),
    .val_i   (enc_val),
    .char_o  (enc_char)
  );

  // Index of the final digit, 2*nterms-2, widened so nterms=MAX_TERMS fits
  logic [CNT_W:0] last_idx;
  logic           at_last;

  assign last_idx = {nterms_q, 1'b0} - (CNT_W + 1)'(2);
  assign at_last  = ({1'b0, idx_q} == last_idx);

  // Next-state logic: launch, advance on handshake, single-cycle DONE
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    digits_d   = digits_q;
    ops_d      = ops_q;
    nterms_d   = nterms_q;
    out_char_d = out_char_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            digits_d   = digits;
            ops_d      = ops;
            nterms_d   = nterms;
            idx_d      = '0;
            out_char_d = enc_char;
            state_d    = EMIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (at_last) begin
            out_char_d = 8'h00;
            state_d    = DONE;
          end else begin
            idx_d      = idx_q + CNT_W'(1);
            out_char_d = enc_char;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        out_char_d = 8'h00;
        state_d    = IDLE;
      end
    endcase
  end

  // State and datapath registers; clr abandons any string in progress
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      digits_q   <= '0;
      ops_q      <= '0;
      nterms_q   <= '0;
      out_char_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      digits_q   <= digits_d;
      ops_q      <= ops_d;
      nterms_q   <= nterms_d;
      out_char_q <= out_char_d;
      err_q      <= err_d;
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_expr_string_gen.sv
// Scoreboard bench for expr_string_gen: stimulus pushes expected characters
// and string lengths; a negedge monitor pops and compares on each handshake.
module tb_expr_string_gen;

  localparam int MAX_TERMS = 4;
  localparam int CNT_W     = 3;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] nterms = '0;
  logic [15:0]      digits = '0;
  logic [5:0]       ops = '0;
  logic             out_ready = 1'b0;
  logic [7:0]       out_char;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             err;

  expr_string_gen #(.MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .nterms    (nterms),
    .digits    (digits),
    .ops       (ops),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         len_q[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         chars_seen = 0;
  int         rec_state = 0;
  logic       hold_valid = 1'b0;
  logic [7:0] hold_char = 8'h00;
  int         ready_mode = 0;
  logic       ready_level = 1'b1;
  int         rcyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expect the first n characters of s; the length is expected only for a full string
  task automatic push_str(input string s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s[i]);
    if (n == s.len()) len_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n, input logic [15:0] d, input logic [5:0] o);
    @(posedge clk);
    #1;
    nterms = n;
    digits = d;
    ops    = o;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (!done && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("done_seen", done, 1);
  endtask

  // out_ready driver: fixed level or the 1,0,0,1 pattern
  always @(posedge clk) begin
    #2;
    if (ready_mode != 0) begin
      out_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
      rcyc++;
    end else begin
      out_ready = ready_level;
    end
  end

  // Monitor: handshakes, stall stability, done/err pulses, recognizer model
  always @(negedge clk) begin
    logic [7:0] e;
    logic       is_op_c;
    if (clr) begin
      chars_seen = 0;
      rec_state  = 0;
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("stall_valid", out_valid, 1);
        check("stall_char", out_char, hold_char);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char: got %0h expected none", out_char);
        end else begin
          e = exp_q.pop_front();
          check("char", out_char, e);
        end
        chars_seen++;
        is_op_c = (out_char == 8'h2B) || (out_char == 8'h2D) ||
                  (out_char == 8'h2A) || (out_char == 8'h2F);
        case (rec_state)
          0:       rec_state = (out_char >= 8'h30 && out_char <= 8'h39) ? 1 : 2;
          1:       rec_state = is_op_c ? 0 : 2;
          default: rec_state = 2;
        endcase
      end
      hold_valid = out_valid && !out_ready;
      hold_char  = out_char;
      if (done) begin
        done_cnt++;
        if (len_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          check("string_len", chars_seen, len_q.pop_front());
        end
        check("recognizer_accept", rec_state, 1);
        chars_seen = 0;
        rec_state  = 0;
      end
      if (err) err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int e_before;

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_out_char", out_char, 0);
    clr = 1'b0;
    tick();

    // S1: "1+2*3" at full throughput
    push_str("1+2*3", 5);
    do_start(3'd3, 16'h0321, 6'b00_10_00);
    check("s1_first_valid", out_valid, 1);
    check("s1_busy", busy, 1);
    check("s1_first_char", out_char, 8'h31);
    wait_done(20, cyc);
    check("s1_latency", cyc, 5);
    check("s1_done_busy", busy, 0);
    tick();
    check("s1_done_pulse", done, 0);
    check("s1_idle_busy", busy, 0);
    check("s1_done_cnt", done_cnt, 1);

    // S2: same string with out_ready toggling 1,0,0,1
    rcyc = 0;
    ready_mode = 1;
    push_str("1+2*3", 5);
    do_start(3'd3, 16'h0321, 6'b00_10_00);
    wait_done(60, cyc);
    ready_mode = 0;
    tick();
    check("s2_done_cnt", done_cnt, 2);
    check("s2_queue_empty", exp_q.size(), 0);

    // S3: single digit (unused digits hold non-BCD values), then rejects
    push_str("9", 1);
    do_start(3'd1, 16'hFFF9, 6'b0);
    wait_done(10, cyc);
    check("s3_single_len_cyc", cyc, 1);
    tick();
    check("s3_done_cnt", done_cnt, 3);

    do_start(3'd0, 16'h0321, 6'b0);
    check("s3_err_n0", err, 1);
    check("s3_busy_n0", busy, 0);
    check("s3_valid_n0", out_valid, 0);
    tick();
    check("s3_err_n0_clear", err, 0);
    check("s3_busy_n0_after", busy, 0);

    do_start(3'd2, 16'h004A, 6'b0);
    check("s3_err_bad_d0", err, 1);
    check("s3_valid_bad_d0", out_valid, 0);
    tick();
    check("s3_valid_bad_d0_after", out_valid, 0);

    do_start(3'd2, 16'h00A4, 6'b0);
    check("s3_err_bad_d1", err, 1);
    tick();

    do_start(3'd5, 16'h4321, 6'b0);
    check("s3_err_n5", err, 1);
    tick();
    check("s3_err_cnt", err_cnt, 4);

    // S4: start during EMIT ignored; start in the IDLE cycle after DONE accepted
    e_before = err_cnt;
    rcyc = 0;
    ready_mode = 1;
    push_str("5-6", 3);
    do_start(3'd2, 16'h0065, 6'b00_00_01);
    tick();
    nterms = 3'd4;
    digits = 16'h1111;
    ops    = 6'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(40, cyc);
    ready_mode = 0;
    push_str("7*8", 3);
    nterms = 3'd2;
    digits = 16'h0087;
    ops    = 6'b00_00_10;
    start  = 1'b1;
    tick();
    check("s4_done_start_ignored", busy, 0);
    tick();
    start  = 1'b0;
    check("s4_restart_valid", out_valid, 1);
    check("s4_restart_char", out_char, 8'h37);
    wait_done(20, cyc);
    tick();
    check("s4_done_cnt", done_cnt, 5);
    check("s4_no_err", err_cnt, e_before);

    // S5: clr mid-string at index 3, then a clean restart
    push_str("1+2-3*4", 3);
    do_start(3'd4, 16'h4321, 6'b10_01_00);
    tick();
    tick();
    tick();
    check("s5_idx3_char", out_char, 8'h2D);
    clr = 1'b1;
    ready_level = 1'b0;
    tick();
    check("s5_clr_valid", out_valid, 0);
    check("s5_clr_busy", busy, 0);
    check("s5_clr_done", done, 0);
    clr = 1'b0;
    ready_level = 1'b1;
    tick();
    check("s5_queue_empty", exp_q.size(), 0);
    check("s5_no_done", done_cnt, 5);
    push_str("1+2-3*4", 7);
    do_start(3'd4, 16'h4321, 6'b10_01_00);
    check("s5_restart_char", out_char, 8'h31);
    wait_done(20, cyc);
    check("s5_len_cyc", cyc, 7);
    tick();

    // S6: max terms using '/', '*', '-'
    push_str("9/8*0-1", 7);
    do_start(3'd4, 16'h1089, 6'b01_10_11);
    wait_done(20, cyc);
    check("s6_len_cyc", cyc, 7);
    tick();

    // Final bookkeeping
    check("end_done_cnt", done_cnt, 7);
    check("end_err_cnt", err_cnt, 4);
    check("end_char_queue", exp_q.size(), 0);
    check("end_len_queue", len_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
